softex_red_sum_ctrl: RTL and testbench

SOFTEX_RED_SUM_CTRL -- requirements
Module: softex_red_sum_ctrl

---
 rtl/softex_red_sum_ctrl_if.sv | 45 ++++
 rtl/softex_red_sum_ctrl.sv | 158 +++++++++++++++
 tb/tb_softex_red_sum_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softex_red_sum_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : softex_red_sum_ctrl_if
// Brief   : Upstream, datapath and result handshakes of the reduction-sum
//           controller, grouped into one bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface softex_red_sum_ctrl_if #(
  parameter int VECT_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32
) ();
  logic                  start_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  abort_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  dp_valid_o;
  logic                  dp_ready_i;
  logic [VECT_WIDTH-1:0] dp_strb_o;
  logic                  dp_clear_o;
  logic                  dp_enable_o;
  logic                  dp_busy_i;
  logic [ACC_WIDTH-1:0]  dp_res_i;
  logic [ACC_WIDTH-1:0]  res_o;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, len_i, abort_i, in_valid_i, dp_ready_i, dp_busy_i,
           dp_res_i, res_ready_i,
    output in_ready_o, dp_valid_o, dp_strb_o, dp_clear_o, dp_enable_o,
           res_o, res_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, len_i, abort_i, in_valid_i, dp_ready_i, dp_busy_i,
           dp_res_i, res_ready_i,
    input  in_ready_o, dp_valid_o, dp_strb_o, dp_clear_o, dp_enable_o,
           res_o, res_valid_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/softex_red_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : softex_red_sum_ctrl
// Brief   : Sequences a sum reduction: clears the accumulator, feeds
//           ceil(len/VECT_WIDTH) masked beats, drains, and hands off the result.
// Revision: 1.0 - initial release
// ============================================================================
module softex_red_sum_ctrl #(
  parameter int VECT_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  softex_red_sum_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] c_vect_len = LEN_WIDTH'(VECT_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [ACC_WIDTH-1:0]  res_q;
  logic                  r_drain_first;

  logic                  w_abort;
  logic [LEN_WIDTH-1:0]  w_step;
  logic [VECT_WIDTH-1:0] w_lane_mask;
  logic                  w_rem_load;
  logic                  w_rem_dec;
  logic                  w_res_zero;
  logic                  w_res_cap;
  logic                  w_in_ready;
  logic                  w_dp_valid;
  logic [VECT_WIDTH-1:0] w_strb;
  logic                  w_clear;
  logic                  w_enable;
  logic                  w_res_valid;
  logic                  w_done;

  assign w_abort = bus.abort_i && (r_state != S_IDLE);
  assign w_step  = (rem_q >= c_vect_len) ? c_vect_len : rem_q;

  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < VECT_WIDTH; i++) begin
      w_lane_mask[i] = (32'(rem_q) > i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_load  = 1'b0;
    w_rem_dec   = 1'b0;
    w_res_zero  = 1'b0;
    w_res_cap   = 1'b0;
    w_in_ready  = 1'b0;
    w_dp_valid  = 1'b0;
    w_strb      = '0;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    w_res_valid = 1'b0;
    w_done      = 1'b0;
    // Abort wins over everything and suppresses any handshake in its cycle.
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i != '0) begin
              w_rem_load  = 1'b1;
              w_state_nxt = S_CLEAR;
            end else begin
              w_res_zero  = 1'b1;
              w_state_nxt = S_OUTPUT;
            end
          end
        end
        S_CLEAR: begin
          w_clear     = 1'b1;
          w_state_nxt = S_FEED;
        end
        S_FEED: begin
          w_enable   = 1'b1;
          w_dp_valid = bus.in_valid_i;
          w_in_ready = bus.dp_ready_i;
          w_strb     = w_lane_mask;
          if (bus.in_valid_i && bus.dp_ready_i) begin
            w_rem_dec = 1'b1;
            if (rem_q <= c_vect_len) w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          w_enable = 1'b1;
          // Skip the entry cycle so dp_busy_i can reflect the final beat.
          if (!r_drain_first && !bus.dp_busy_i) begin
            w_res_cap   = 1'b1;
            w_state_nxt = S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          w_res_valid = 1'b1;
          if (bus.res_ready_i) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q         <= '0;
      res_q         <= '0;
      r_drain_first <= 1'b0;
    end else begin
      r_drain_first <= (w_state_nxt == S_DRAIN) && (r_state != S_DRAIN);
      if (w_abort)         rem_q <= '0;
      else if (w_rem_load) rem_q <= bus.len_i;
      else if (w_rem_dec)  rem_q <= rem_q - w_step;
      if (w_res_zero)      res_q <= '0;
      else if (w_res_cap)  res_q <= bus.dp_res_i;
    end
  end

  // Outputs are forced low while reset is asserted, whatever the state.
  assign bus.in_ready_o  = !rst_i && w_in_ready;
  assign bus.dp_valid_o  = !rst_i && w_dp_valid;
  assign bus.dp_strb_o   = rst_i ? '0 : w_strb;
  assign bus.dp_clear_o  = !rst_i && w_clear;
  assign bus.dp_enable_o = !rst_i && w_enable;
  assign bus.res_o       = rst_i ? '0 : res_q;
  assign bus.res_valid_o = !rst_i && w_res_valid;
  assign bus.busy_o      = !rst_i && (r_state != S_IDLE);
  assign bus.done_o      = !rst_i && w_done;

endmodule
`default_nettype wire

// File: tb/tb_softex_red_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_softex_red_sum_ctrl
// Brief   : Directed bench for softex_red_sum_ctrl with a job-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_softex_red_sum_ctrl;
  localparam int VW = 16;
  localparam int LW = 16;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  softex_red_sum_ctrl_if #(.VECT_WIDTH(VW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) bus ();

  softex_red_sum_ctrl #(.VECT_WIDTH(VW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Job-level model: a job is clearing, then consuming elements, then
  // draining, then holding a result until it is taken.
  bit          m_active, m_cleared, m_have;
  int          m_left, m_drain;
  logic [31:0] m_result;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_cleared = 0; m_have = 0; m_left = 0; m_drain = 0;
      m_result = '0;
    end else if ((m_active || m_have) && bus.abort_i) begin
      m_active = 0; m_have = 0; m_left = 0;
    end else if (!(m_active || m_have)) begin
      if (bus.start_i) begin
        if (bus.len_i == 0) begin
          m_result = '0; m_have = 1;
        end else begin
          m_active = 1; m_cleared = 0; m_left = int'(bus.len_i); m_drain = 0;
        end
      end
    end else if (m_have) begin
      if (bus.res_ready_i) m_have = 0;
    end else if (!m_cleared) begin
      m_cleared = 1;
    end else if (m_left > 0) begin
      if (bus.in_valid_i && bus.dp_ready_i) m_left -= (m_left < VW) ? m_left : VW;
    end else begin
      if (m_drain > 0 && !bus.dp_busy_i) begin
        m_result = bus.dp_res_i; m_have = 1; m_active = 0;
      end
      m_drain++;
    end
  end

  always @(negedge clk) begin
    logic        busy_m, ab, feeding;
    logic [15:0] e_strb;
    busy_m  = m_active || m_have;
    ab      = busy_m && bus.abort_i;
    feeding = !rst && !ab && m_active && m_cleared && (m_left > 0);
    e_strb  = '0;
    if (feeding) e_strb = (m_left >= VW) ? 16'hFFFF : 16'((32'd1 << m_left) - 32'd1);
    chk("in_ready",  bus.in_ready_o,  feeding && bus.dp_ready_i);
    chk("dp_valid",  bus.dp_valid_o,  feeding && bus.in_valid_i);
    chk("dp_strb",   bus.dp_strb_o,   e_strb);
    chk("dp_clear",  bus.dp_clear_o,  !rst && (ab || (m_active && !m_cleared)));
    chk("dp_enable", bus.dp_enable_o, !rst && !ab && m_active && m_cleared);
    chk("res_valid", bus.res_valid_o, !rst && !ab && m_have);
    chk("done",      bus.done_o,      !rst && !ab && m_have && bus.res_ready_i);
    chk("busy",      bus.busy_o,      !rst && busy_m);
    chk("res",       bus.res_o,       rst ? 32'h0 : m_result);
  end

  // Event monitor for the hand-computed per-test expectations.
  int          cur_c;
  int          clr_cnt, clr_first, beats, last_beat, valid_cnt, first_valid, done_cnt, done_c;
  logic [15:0] strb0, strb1;
  logic [31:0] res_at_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dp_clear_o) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = cur_c;
      end
      if (bus.dp_valid_o && bus.in_ready_o) begin
        if (beats == 0) strb0 = bus.dp_strb_o;
        if (beats == 1) strb1 = bus.dp_strb_o;
        beats++;
        last_beat = cur_c;
      end
      if (bus.res_valid_o) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cur_c;
      end
      if (bus.done_o) begin
        done_cnt++; done_c = cur_c; res_at_done = bus.res_o;
      end
    end
  end

  task automatic idle_inputs();
    bus.start_i = 0; bus.len_i = '0; bus.abort_i = 0; bus.in_valid_i = 0;
    bus.dp_ready_i = 0; bus.dp_busy_i = 0; bus.dp_res_i = '0; bus.res_ready_i = 0;
  endtask

  task automatic begin_test();
    idle_inputs();
    cur_c = 0; clr_cnt = 0; clr_first = -1; beats = 0; last_beat = -1;
    valid_cnt = 0; first_valid = -1; done_cnt = 0; done_c = -1;
    strb0 = '0; strb1 = '0; res_at_done = '0;
  endtask

  initial begin
    begin_test();
    rst = 1;
    bus.start_i = 1; bus.len_i = 16'd5; bus.abort_i = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_clear", bus.dp_clear_o, 0);
      chk("rst_res", bus.res_o, 0);
    end
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_busy", bus.busy_o, 0);
    chk("post_rst_res_valid", bus.res_valid_o, 0);
    @(posedge clk); #1;

    // len=32, valid/ready high: two full beats
    begin_test();
    for (int c = 0; c < 9; c++) begin
      cur_c = c;
      bus.start_i = (c == 0); bus.len_i = 16'd32; bus.in_valid_i = 1; bus.dp_ready_i = 1;
      bus.res_ready_i = 1; bus.dp_res_i = 32'h1234_5678;
      @(negedge clk);
      if (c == 2) chk("a_strb_first", bus.dp_strb_o, 16'hFFFF);
      @(posedge clk); #1;
    end
    chk("a_clr_first", clr_first, 1);
    chk("a_clr_cnt", clr_cnt, 1);
    chk("a_beats", beats, 2);
    chk("a_strbs", {strb0, strb1}, 32'hFFFF_FFFF);
    chk("a_first_valid", first_valid, 6);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_res", res_at_done, 32'h1234_5678);

    // len=20: full beat then a 4-lane beat
    begin_test();
    for (int c = 0; c < 9; c++) begin
      cur_c = c;
      bus.start_i = (c == 0); bus.len_i = 16'd20; bus.in_valid_i = 1; bus.dp_ready_i = 1;
      bus.res_ready_i = 1; bus.dp_res_i = 32'h0000_BEEF;
      @(negedge clk);
      if (c == 4) begin
        chk("b_model_left", m_left, 0);
        chk("b_drain_strb", bus.dp_strb_o, 16'h0000);
        chk("b_drain_enable", bus.dp_enable_o, 1);
      end
      @(posedge clk); #1;
    end
    chk("b_beats", beats, 2);
    chk("b_strbs", {strb0, strb1}, 32'hFFFF_000F);
    chk("b_res", res_at_done, 32'h0000_BEEF);

    // len=0: straight to a zero result
    begin_test();
    for (int c = 0; c < 4; c++) begin
      cur_c = c;
      bus.start_i = (c == 0); bus.len_i = 16'd0; bus.in_valid_i = 1; bus.dp_ready_i = 1;
      bus.res_ready_i = 1; bus.dp_res_i = 32'hFFFF_FFFF;
      @(negedge clk);
      if (c == 1) chk("c_res_o", bus.res_o, 32'h0000_0000);
      @(posedge clk); #1;
    end
    chk("c_clr_cnt", clr_cnt, 0);
    chk("c_beats", beats, 0);
    chk("c_first_valid", first_valid, 1);
    chk("c_done_cnt", done_cnt, 1);

    // len=24 with dp_ready low for 5 cycles after the first beat
    begin_test();
    for (int c = 0; c < 14; c++) begin
      cur_c = c;
      bus.start_i = (c == 0); bus.len_i = 16'd24; bus.in_valid_i = 1;
      bus.dp_ready_i = !(c >= 3 && c <= 7); bus.res_ready_i = 1; bus.dp_res_i = 32'h0000_0024;
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        chk("d_stall_ready", bus.in_ready_o, 0);
        chk("d_stall_strb", bus.dp_strb_o, 16'h00FF);
      end
      @(posedge clk); #1;
    end
    chk("d_beats", beats, 2);
    chk("d_strbs", {strb0, strb1}, 32'hFFFF_00FF);
    chk("d_last_beat", last_beat, 8);
    chk("d_done_c", done_c, 11);

    // abort in the second beat cycle
    begin_test();
    for (int c = 0; c < 8; c++) begin
      cur_c = c;
      bus.start_i = (c == 0); bus.len_i = 16'd64; bus.in_valid_i = 1; bus.dp_ready_i = 1;
      bus.abort_i = (c == 3); bus.res_ready_i = 1;
      @(negedge clk);
      if (c == 4) chk("e_idle_after_abort", bus.busy_o, 0);
      @(posedge clk); #1;
    end
    chk("e_beats", beats, 1);
    chk("e_clr_cnt", clr_cnt, 2);
    chk("e_done_cnt", done_cnt, 0);
    chk("e_valid_cnt", valid_cnt, 0);

    // abort in IDLE ignored; start in OUTPUT ignored; abort in OUTPUT
    begin_test();
    for (int c = 0; c < 10; c++) begin
      cur_c = c;
      bus.start_i = (c == 0 || c == 6); bus.abort_i = (c == 0 || c == 7);
      bus.len_i = 16'd16; bus.in_valid_i = 1; bus.dp_ready_i = 1;
      bus.res_ready_i = 0; bus.dp_res_i = 32'hA5A5_0001;
      @(negedge clk);
      if (c == 8) chk("f_idle", bus.busy_o, 0);
      @(posedge clk); #1;
    end
    chk("f_clr_first", clr_first, 1);
    chk("f_clr_cnt", clr_cnt, 2);
    chk("f_beats", beats, 1);
    chk("f_valid_cnt", valid_cnt, 2);
    chk("f_done_cnt", done_cnt, 0);

    // busy datapath delays capture; result held while res_ready_i is low
    begin_test();
    for (int c = 0; c < 13; c++) begin
      cur_c = c;
      bus.start_i = (c == 0); bus.len_i = 16'd16; bus.in_valid_i = 1; bus.dp_ready_i = 1;
      bus.dp_busy_i = (c <= 5);
      bus.dp_res_i = (c <= 6) ? 32'h4049_0FDB : 32'hDEAD_BEEF;
      bus.res_ready_i = (c >= 10);
      @(negedge clk);
      if (c >= 7 && c <= 9) chk("g_res_hold", bus.res_o, 32'h4049_0FDB);
      @(posedge clk); #1;
    end
    chk("g_first_valid", first_valid, 7);
    chk("g_valid_cnt", valid_cnt, 4);
    chk("g_done_cnt", done_cnt, 1);
    chk("g_done_c", done_c, 10);
    chk("g_res", res_at_done, 32'h4049_0FDB);

    // reset mid-feed beats abort and start
    begin_test();
    for (int c = 0; c < 6; c++) begin
      cur_c = c;
      rst = (c == 2);
      bus.start_i = (c == 0 || c == 2); bus.abort_i = (c == 2);
      bus.len_i = 16'd32; bus.in_valid_i = 1; bus.dp_ready_i = 1; bus.res_ready_i = 1;
      @(negedge clk);
      if (c == 2) begin
        chk("h_rst_clear", bus.dp_clear_o, 0);
        chk("h_rst_valid", bus.dp_valid_o, 0);
      end
      if (c == 3) begin
        chk("h_busy", bus.busy_o, 0);
        chk("h_res", bus.res_o, 32'h0);
      end
      @(posedge clk); #1;
    end
    rst = 0;
    chk("h_clr_cnt", clr_cnt, 1);
    chk("h_beats", beats, 0);
    chk("h_done_cnt", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
